// File: rtl/hp_divider_seq.sv
// Iterative IEEE-754 half-precision divider using restoring mantissa division.
// The datapath produces one quotient bit per clock and uses a start/busy/done handshake.
module hp_divider_seq #(
  parameter int EXP_BIAS = 15,
  parameter int QBITS    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] hp_inA,
  input  logic [15:0] hp_inB,
  output logic        busy,
  output logic        done,
  output logic [15:0] hp_quotient,
  output logic [1:0]  Exceptions
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SPEC = 2'b01,
    DIV  = 2'b10,
    NORM = 2'b11
  } state_t;

  state_t             state_r;
  state_t             next_state_s;

  logic               sign_r;
  logic [10:0]        mb_r;
  logic [12:0]        rem_r;
  logic [11:0]        q_r;
  logic [3:0]         cnt_r;
  logic signed [6:0]  e_r;
  logic [1:0]         spec_exc_r;

  logic [4:0]         exp_a_s;
  logic [4:0]         exp_b_s;
  logic [9:0]         man_a_s;
  logic [9:0]         man_b_s;
  logic               spec_s;
  logic [1:0]         spec_exc_s;
  logic signed [6:0]  e_calc_s;

  logic               ge_s;
  logic [12:0]        rem_sub_s;
  logic [12:0]        rem_next_s;
  logic signed [6:0]  e_norm_s;
  logic [9:0]         man_norm_s;

  logic               load_s;
  logic               write_spec_s;
  logic               write_norm_s;

  assign exp_a_s  = hp_inA[14:10];
  assign exp_b_s  = hp_inB[14:10];
  assign man_a_s  = hp_inA[9:0];
  assign man_b_s  = hp_inB[9:0];
  assign e_calc_s = $signed({2'b00, exp_a_s}) - $signed({2'b00, exp_b_s}) + $signed(7'(EXP_BIAS));

  // Operand classification in priority order; only meaningful on the accepting edge
  always_comb begin
    spec_s     = 1'b1;
    spec_exc_s = 2'b11;
    if ((exp_a_s == 5'd31) || (exp_b_s == 5'd31)) begin
      spec_exc_s = 2'b11;
    end else if (((exp_a_s == 5'd0) && (man_a_s != 10'd0)) ||
                 ((exp_b_s == 5'd0) && (man_b_s != 10'd0))) begin
      spec_exc_s = 2'b11;
    end else if (exp_b_s == 5'd0) begin
      spec_exc_s = 2'b11;
    end else if (exp_a_s == 5'd0) begin
      spec_exc_s = 2'b00;
    end else begin
      spec_s     = 1'b0;
      spec_exc_s = 2'b00;
    end
  end

  // One restoring-division step and the truncating normalisation of the finished quotient
  always_comb begin
    ge_s       = (rem_r >= {2'b00, mb_r});
    rem_sub_s  = ge_s ? (rem_r - {2'b00, mb_r}) : rem_r;
    rem_next_s = rem_sub_s << 1;
    if (q_r[11]) begin
      e_norm_s   = e_r;
      man_norm_s = q_r[10:1];
    end else begin
      e_norm_s   = e_r - 7'sd1;
      man_norm_s = q_r[9:0];
    end
  end

  // Next-state logic and per-state strobes
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    write_spec_s = 1'b0;
    write_norm_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = spec_s ? SPEC : DIV;
        end else begin
          next_state_s = IDLE;
        end
      end
      SPEC: begin
        write_spec_s = 1'b1;
        next_state_s = IDLE;
      end
      DIV: begin
        if (cnt_r == 4'd0) begin
          next_state_s = NORM;
        end else begin
          next_state_s = DIV;
        end
      end
      NORM: begin
        write_norm_s = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture and iterative quotient generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r     <= 1'b0;
      mb_r       <= 11'd0;
      rem_r      <= 13'd0;
      q_r        <= 12'd0;
      cnt_r      <= 4'd0;
      e_r        <= 7'sd0;
      spec_exc_r <= 2'b00;
    end else if (load_s) begin
      sign_r     <= hp_inA[15] ^ hp_inB[15];
      mb_r       <= {1'b1, man_b_s};
      rem_r      <= {2'b01, man_a_s};
      q_r        <= 12'd0;
      cnt_r      <= 4'(QBITS - 1);
      e_r        <= e_calc_s;
      spec_exc_r <= spec_exc_s;
    end else if (state_r == DIV) begin
      rem_r <= rem_next_s;
      q_r   <= {q_r[10:0], ge_s};
      cnt_r <= cnt_r - 4'd1;
    end else begin
      rem_r <= rem_r;
      q_r   <= q_r;
      cnt_r <= cnt_r;
    end
  end

  // Registered handshake and result outputs; results only move on a writing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hp_quotient <= 16'h0000;
      Exceptions  <= 2'b00;
    end else begin
      busy <= (next_state_s != IDLE);
      done <= write_spec_s | write_norm_s;
      if (write_spec_s) begin
        hp_quotient <= 16'h0000;
        Exceptions  <= spec_exc_r;
      end else if (write_norm_s) begin
        if (e_norm_s < 7'sd1) begin
          hp_quotient <= 16'h0000;
          Exceptions  <= 2'b10;
        end else if (e_norm_s > 7'sd30) begin
          hp_quotient <= 16'h0000;
          Exceptions  <= 2'b01;
        end else begin
          hp_quotient <= {sign_r, e_norm_s[4:0], man_norm_s};
          Exceptions  <= 2'b00;
        end
      end else begin
        hp_quotient <= hp_quotient;
        Exceptions  <= Exceptions;
      end
    end
  end

endmodule

// File: tb/tb_hp_divider_seq.sv
// Directed self-checking bench for hp_divider_seq with hand-computed quotients.
module tb_hp_divider_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] hp_inA;
  logic [15:0] hp_inB;
  logic        busy;
  logic        done;
  logic [15:0] hp_quotient;
  logic [1:0]  Exceptions;

  int compared;
  int mismatched;

  hp_divider_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hp_inA(hp_inA), .hp_inB(hp_inB),
    .busy(busy), .done(done), .hp_quotient(hp_quotient), .Exceptions(Exceptions)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands with start; returns #1 after the accepting edge E0
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    hp_inA = a;
    hp_inB = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Wait for done starting n0 edges after E0; check latency, busy, and result
  task automatic finish(input string tag, input int n0, input int lat,
                        input logic [15:0] exp_q, input logic [1:0] exp_exc);
    int n;
    bit busy_ok;
    n = n0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 16'(n), 16'(lat));
    check({tag, "_busy_run"}, {15'd0, busy_ok}, 16'd1);
    check({tag, "_busy_done"}, {15'd0, busy}, 16'd0);
    check({tag, "_q"}, hp_quotient, exp_q);
    check({tag, "_exc"}, {14'd0, Exceptions}, {14'd0, exp_exc});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    hp_inA = 16'h0000;
    hp_inB = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", hp_quotient, 16'h0000);
    check("rst_exc", {14'd0, Exceptions}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal-path divisions
    launch(16'h4600, 16'h4000);
    check("t1_busy_e0", {15'd0, busy}, 16'd1);
    finish("t1", 0, 13, 16'h4200, 2'b00);
    @(posedge clk); #1;
    check("t1_done_pulse", {15'd0, done}, 16'd0);
    check("t1_hold", hp_quotient, 16'h4200);

    launch(16'h3C00, 16'h4200);
    finish("t2a", 0, 13, 16'h3555, 2'b00);
    launch(16'hC500, 16'h4100);
    finish("t2b", 0, 13, 16'hC000, 2'b00);

    // Special cases complete one edge after E0
    launch(16'h3C00, 16'h0000);
    finish("t3_divzero", 0, 1, 16'h0000, 2'b11);
    launch(16'h0000, 16'h4000);
    finish("t3_zero", 0, 1, 16'h0000, 2'b00);
    launch(16'h7C00, 16'h4000);
    finish("t3_inf", 0, 1, 16'h0000, 2'b11);
    launch(16'h011E, 16'h4000);
    finish("t3_denorm", 0, 1, 16'h0000, 2'b11);
    launch(16'h0000, 16'h0000);
    finish("t3_zz", 0, 1, 16'h0000, 2'b11);

    // Range limits
    launch(16'h7BFF, 16'h0400);
    finish("t4_ovf", 0, 13, 16'h0000, 2'b01);
    launch(16'h0400, 16'h7BFF);
    finish("t4_unf", 0, 13, 16'h0000, 2'b10);

    // start pulsed at E5 is ignored
    launch(16'h4600, 16'h4000);
    repeat (4) begin @(posedge clk); #1; end
    hp_inA = 16'h3C00;
    hp_inB = 16'h4200;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    finish("t5_ignore", 5, 13, 16'h4200, 2'b00);
    // back-to-back: start raised in the done cycle
    launch(16'h3C00, 16'h4200);
    finish("t5_b2b", 0, 13, 16'h3555, 2'b00);
    @(posedge clk); #1;
    check("t5_idle", {15'd0, busy}, 16'd0);
    check("t5_nodone", {15'd0, done}, 16'd0);

    // Reset in the middle of a division
    launch(16'hC500, 16'h4100);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("t6_q", hp_quotient, 16'h0000);
    check("t6_exc", {14'd0, Exceptions}, 16'd0);
    check("t6_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      check("t6_no_done", {15'd0, saw_done}, 16'd0);
    end
    launch(16'h4600, 16'h4000);
    finish("t6_fresh", 0, 13, 16'h4200, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
